// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the RV32 5-stage pipeline controller.
//   stage_t       : stage index F=0 .. W=4, used to index stall/flush vectors
//   N_STAGES      : number of pipeline stages
//   pc_sel_t      : fetch PC source select
//   pctrl_state_t : controller sequencing state (RUN / KILL / TRAP_WAIT)
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    F = 3'd0,
    D = 3'd1,
    E = 3'd2,
    M = 3'd3,
    W = 3'd4
  } stage_t;

  localparam int N_STAGES = 5;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_BR   = 2'd1,
    PC_TRAP = 2'd2,
    PC_EPC  = 2'd3
  } pc_sel_t;

  // Plain vector plus constants so older code can compare against raw encodings.
  typedef logic [1:0] pctrl_state_t;
  localparam pctrl_state_t RUN       = 2'd0;
  localparam pctrl_state_t KILL      = 2'd1;
  localparam pctrl_state_t TRAP_WAIT = 2'd2;

endpackage

// File: rtl/pipe_ctrl_stall_vec.sv
// pipe_stall_vec: combinational priority / cumulative stall-flush encoder.
// Inputs : raw hazard/redirect/trap requests plus sequencing qualifiers from
//          the controller FSM (br_en, hold_f, drop_f).
// Outputs: per-stage stall/flush, PC load strobe and source, and the
//          accept strobes the FSM uses to pick its next state.
module pipe_stall_vec
  import pipe_ctrl_pkg::*;
(
  input  logic    lu_hazard,
  input  logic    imem_wait,
  input  logic    dmem_wait,
  input  logic    mdu_busy,
  input  logic    br_redirect,
  input  logic    trap_req,
  input  logic    trap_ret,
  input  logic    br_en,      // FSM state allows redirects
  input  logic    hold_f,     // FSM holds F (trap settle window)
  input  logic    drop_f,     // FSM discards the stale fetch in F
  output logic    stall [N_STAGES-1:0],
  output logic    flush [N_STAGES-1:0],
  output logic    pc_load,
  output pc_sel_t pc_sel,
  output logic    br_acc,
  output logic    trap_acc
);

  logic hold_e;

  always_comb begin
    trap_acc = trap_req | trap_ret;
    hold_e   = dmem_wait | mdu_busy;
    br_acc   = 1'b0;
    pc_load  = 1'b0;
    pc_sel   = PC_SEQ;
    for (int i = 0; i < N_STAGES; i++) begin
      stall[i] = 1'b0;
      flush[i] = 1'b0;
    end

    if (trap_acc) begin
      // Trap wipes F..M and outranks every memory/MDU hold.
      for (int i = 0; i < N_STAGES - 1; i++) flush[i] = 1'b1;
      pc_load = 1'b1;
      pc_sel  = trap_req ? PC_TRAP : PC_EPC;
    end else begin
      // Redirect only resolves once E is actually advancing.
      br_acc   = br_en & br_redirect & ~hold_e;
      // Cumulative toward F: a hold at stage k holds every older stage.
      stall[M] = dmem_wait;
      stall[E] = hold_e;
      // D is wrong-path on an accepted redirect, so its load-use hold is moot.
      stall[D] = hold_e | (lu_hazard & ~br_acc);
      stall[F] = hold_e | (lu_hazard & ~br_acc) | imem_wait | hold_f;
      if (br_acc) begin
        flush[F] = 1'b1;
        flush[D] = 1'b1;
        pc_load  = 1'b1;
        pc_sel   = PC_BR;
      end
      if (drop_f) flush[F] = 1'b1;
      // A flushed stage must not also hold.
      for (int i = 0; i < N_STAGES; i++)
        if (flush[i]) stall[i] = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller for the 5-stage RV32 pipeline.
// Ports:
//   clk, grst                : clock, synchronous active-high reset
//   lu_hazard .. trap_ret    : hazard, redirect and trap requests
//   stall[], flush[]         : per-stage hold / clear for every pbuffer
//   pc_load, pc_sel          : fetch PC load strobe and source
//   state                    : current sequencing state (debug)
//   stall_cyc, flush_evt     : saturating perf counters, only when
//                              PIPE_CTRL_PERF_EN is defined
// Sequencing: KILL discards a fetch still in flight when a redirect lands;
// TRAP_WAIT holds F for TRAP_CYCLES after a trap/return while CSRs settle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TRAP_CYCLES = 2,   // legal 1..15
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         grst,
  input  logic         lu_hazard,
  input  logic         imem_wait,
  input  logic         dmem_wait,
  input  logic         mdu_busy,
  input  logic         br_redirect,
  input  logic         trap_req,
  input  logic         trap_ret,
  output logic         stall [N_STAGES-1:0],
  output logic         flush [N_STAGES-1:0],
  output logic         pc_load,
  output pc_sel_t      pc_sel,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] flush_evt,
`endif
  output pctrl_state_t state
);

  localparam logic [3:0] TRAP_CNT_INIT = 4'(TRAP_CYCLES - 1);

  // Out-of-range parameters leave this empty block as a marker in elaboration.
  if (TRAP_CYCLES < 1 || TRAP_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
  end

  pctrl_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         infl_q, infl_d;   // fetch issued before the trap still pending

  logic    br_en, hold_f, drop_f;
  logic    enc_stall [N_STAGES-1:0];
  logic    enc_flush [N_STAGES-1:0];
  logic    enc_pc_load, br_acc, trap_acc;
  pc_sel_t enc_pc_sel;

  always_comb begin
    br_en  = (state_q != TRAP_WAIT);
    hold_f = 1'b0;
    drop_f = 1'b0;
    case (state_q)
      // F is already held by imem_wait itself; discard once the response lands.
      KILL:      drop_f = ~imem_wait;
      TRAP_WAIT: begin
        hold_f = 1'b1;
        drop_f = infl_q & ~imem_wait;
      end
      default: ;
    endcase
  end

  pipe_stall_vec u_enc (
    .lu_hazard   (lu_hazard),
    .imem_wait   (imem_wait),
    .dmem_wait   (dmem_wait),
    .mdu_busy    (mdu_busy),
    .br_redirect (br_redirect),
    .trap_req    (trap_req),
    .trap_ret    (trap_ret),
    .br_en       (br_en),
    .hold_f      (hold_f),
    .drop_f      (drop_f),
    .stall       (enc_stall),
    .flush       (enc_flush),
    .pc_load     (enc_pc_load),
    .pc_sel      (enc_pc_sel),
    .br_acc      (br_acc),
    .trap_acc    (trap_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    infl_d  = infl_q;
    if (trap_acc) begin
      state_d = TRAP_WAIT;
      cnt_d   = TRAP_CNT_INIT;
      infl_d  = imem_wait;
    end else begin
      case (state_q)
        RUN:  state_d = (br_acc & imem_wait) ? KILL : RUN;
        KILL: state_d = imem_wait ? KILL : RUN;
        TRAP_WAIT: begin
          if (cnt_q != 4'd0)         cnt_d  = cnt_q - 4'd1;
          if (infl_q && !imem_wait)  infl_d = 1'b0;
          // Leave only when the window is done and no stale fetch remains.
          if (cnt_q == 4'd0 && (!infl_q || !imem_wait)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
    end
  end

  // Reset forces a quiet, fully flushed pipeline regardless of requests.
  always_comb begin
    pc_load = grst ? 1'b0 : enc_pc_load;
    pc_sel  = grst ? PC_SEQ : enc_pc_sel;
    for (int i = 0; i < N_STAGES; i++) begin
      stall[i] = grst ? 1'b0 : enc_stall[i];
      flush[i] = grst ? 1'b1 : enc_flush[i];
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_evt_q, flush_evt_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_evt_d = flush_evt_q;
    if (stall[F] && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + 1'b1;
    if (flush[D] && flush_evt_q != '1) flush_evt_d = flush_evt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      stall_cyc_q <= '0;
      flush_evt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_evt_q <= flush_evt_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_evt = flush_evt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl with a scoreboard. Each
// stimulus cycle pushes its hand-computed expected outputs; a monitor pops
// and compares on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic grst = 1'b1;
  logic lu_hazard = 1'b0, imem_wait = 1'b0, dmem_wait = 1'b0, mdu_busy = 1'b0;
  logic br_redirect = 1'b0, trap_req = 1'b0, trap_ret = 1'b0;
  logic stall [N_STAGES-1:0];
  logic flush [N_STAGES-1:0];
  logic pc_load;
  pc_sel_t pc_sel;
  pctrl_state_t state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc, flush_evt;
  int exp_stall_cyc = 0, exp_flush_evt = 0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.TRAP_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .grst(grst),
    .lu_hazard(lu_hazard), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .mdu_busy(mdu_busy), .br_redirect(br_redirect),
    .trap_req(trap_req), .trap_ret(trap_ret),
    .stall(stall), .flush(flush), .pc_load(pc_load), .pc_sel(pc_sel),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cyc(stall_cyc), .flush_evt(flush_evt),
`endif
    .state(state)
  );

  // Input bits, OR-ed together per vector.
  localparam logic [7:0] I_NONE = 8'h00, I_RST = 8'h80, I_TRQ = 8'h40, I_TRT = 8'h20,
                         I_BR = 8'h10, I_DM = 8'h08, I_MDU = 8'h04, I_LU = 8'h02, I_IM = 8'h01;

  typedef struct packed {
    logic [4:0]   st;   // bit i = stage i
    logic [4:0]   fl;
    logic         pl;
    pc_sel_t      ps;
    pctrl_state_t s;
  } exp_t;

  exp_t exp_q[$];
  int   tag_q[$];
  int   n_tests = 0, n_fail = 0, cyc_n = 0;

  task automatic cyc(input logic [7:0] iv, input logic [4:0] st, input logic [4:0] fl,
                     input logic pl, input pc_sel_t ps, input pctrl_state_t s);
    exp_t e;
    @(posedge clk); #1;
    grst = iv[7]; trap_req = iv[6]; trap_ret = iv[5]; br_redirect = iv[4];
    dmem_wait = iv[3]; mdu_busy = iv[2]; lu_hazard = iv[1]; imem_wait = iv[0];
    e.st = st; e.fl = fl; e.pl = pl; e.ps = ps; e.s = s;
    cyc_n++;
    exp_q.push_back(e);
    tag_q.push_back(cyc_n);
`ifdef PIPE_CTRL_PERF_EN
    if (iv[7]) begin
      exp_stall_cyc = 0; exp_flush_evt = 0;
    end else begin
      exp_stall_cyc += int'(st[0]);
      exp_flush_evt += int'(fl[1]);
    end
`endif
  endtask

  // Monitor: pop one expectation per presented cycle and compare every field.
  initial begin : monitor
    exp_t e;
    int   t;
    logic [4:0] a_st, a_fl;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int i = 0; i < N_STAGES; i++) begin
          a_st[i] = stall[i];
          a_fl[i] = flush[i];
        end
        n_tests += 5;
        if (a_st !== e.st) begin
          n_fail++; $display("FAIL c%0d stall got=%b exp=%b", t, a_st, e.st);
        end
        if (a_fl !== e.fl) begin
          n_fail++; $display("FAIL c%0d flush got=%b exp=%b", t, a_fl, e.fl);
        end
        if (pc_load !== e.pl) begin
          n_fail++; $display("FAIL c%0d pc_load got=%b exp=%b", t, pc_load, e.pl);
        end
        if (pc_sel !== e.ps) begin
          n_fail++; $display("FAIL c%0d pc_sel got=%0d exp=%0d", t, pc_sel, e.ps);
        end
        if (state !== e.s) begin
          n_fail++; $display("FAIL c%0d state got=%0d exp=%0d", t, state, e.s);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    // c1-2 reset outputs, then idle
    cyc(I_RST,                5'b00000, 5'b11111, 0, PC_SEQ,  RUN);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c3-4 load-use
    cyc(I_LU,                 5'b00011, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c5-9 dmem_wait blocks redirect for 3 cycles
    cyc(I_DM | I_BR,          5'b01111, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_DM | I_BR,          5'b01111, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_DM | I_BR,          5'b01111, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_BR,                 5'b00000, 5'b00011, 1, PC_BR,   RUN);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c10-14 redirect during imem_wait -> KILL
    cyc(I_BR | I_IM,          5'b00000, 5'b00011, 1, PC_BR,   RUN);
    cyc(I_IM,                 5'b00001, 5'b00000, 0, PC_SEQ,  KILL);
    cyc(I_IM,                 5'b00001, 5'b00000, 0, PC_SEQ,  KILL);
    cyc(I_NONE,               5'b00000, 5'b00001, 0, PC_SEQ,  KILL);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c15-18 trap over mdu_busy, F held exactly 2 cycles
    cyc(I_TRQ | I_MDU,        5'b00000, 5'b01111, 1, PC_TRAP, RUN);
    cyc(I_NONE,               5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c19-23 mret with fetch in flight past the settle window
    cyc(I_TRT | I_IM,         5'b00000, 5'b01111, 1, PC_EPC,  RUN);
    cyc(I_IM,                 5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_IM,                 5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00000, 5'b00001, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c24-27 trap_req beats trap_ret and dmem; br ignored; nested trap
    cyc(I_TRQ | I_TRT | I_DM, 5'b00000, 5'b01111, 1, PC_TRAP, RUN);
    cyc(I_BR,                 5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_TRQ,                5'b00000, 5'b01111, 1, PC_TRAP, TRAP_WAIT);
    cyc(I_DM,                 5'b01111, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    // c28-31 reset held 3 cycles starting in TRAP_WAIT
    cyc(I_RST,                5'b00000, 5'b11111, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_RST,                5'b00000, 5'b11111, 0, PC_SEQ,  RUN);
    cyc(I_RST | I_BR | I_LU,  5'b00000, 5'b11111, 0, PC_SEQ,  RUN);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c32-37 mdu blocks redirect; redirect masks load-use; mixed holds
    cyc(I_MDU | I_BR | I_LU,  5'b00111, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_BR | I_LU,          5'b00000, 5'b00011, 1, PC_BR,   RUN);
    cyc(I_IM,                 5'b00001, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_DM | I_IM | I_LU,   5'b01111, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_LU | I_IM,          5'b00011, 5'b00000, 0, PC_SEQ,  RUN);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);
    // c38-42 trap taken while in KILL
    cyc(I_BR | I_IM,          5'b00000, 5'b00011, 1, PC_BR,   RUN);
    cyc(I_TRQ | I_IM,         5'b00000, 5'b01111, 1, PC_TRAP, KILL);
    cyc(I_NONE,               5'b00000, 5'b00001, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00001, 5'b00000, 0, PC_SEQ,  TRAP_WAIT);
    cyc(I_NONE,               5'b00000, 5'b00000, 0, PC_SEQ,  RUN);

    @(posedge clk); #1;
    grst = 1'b0; trap_req = 1'b0; trap_ret = 1'b0; br_redirect = 1'b0;
    dmem_wait = 1'b0; mdu_busy = 1'b0; lu_hazard = 1'b0; imem_wait = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
`ifdef PIPE_CTRL_PERF_EN
    n_tests += 2;
    if (stall_cyc !== 32'(exp_stall_cyc)) begin
      n_fail++; $display("FAIL stall_cyc got=%0d exp=%0d", stall_cyc, exp_stall_cyc);
    end
    if (flush_evt !== 32'(exp_flush_evt)) begin
      n_fail++; $display("FAIL flush_evt got=%0d exp=%0d", flush_evt, exp_flush_evt);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage RV32 pipeline (F, D, E, M, W).
- Collects hazard and redirect requests from the stages and from the memory interfaces.
- Drives the per-stage stall and flush vectors consumed by every pbuffer instance, plus the PC-select/load strobe for fetch.
- Owns the multi-cycle sequencing after redirects and traps: discarding an in-flight fetch and the trap settle window.

Parameters:
- TRAP_CYCLES, 2, cycles F is held stalled after a trap/return redirect (CSR settle); legal range 1..15.
- CNT_W, 32, width of performance counters (used only with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  clock
- grst  in  1  global reset; synchronous, active-high
- lu_hazard  in  1  load-use hazard detected in D against a load in E
- imem_wait  in  1  instruction memory response not ready this cycle
- dmem_wait  in  1  data memory access in M not complete
- mdu_busy  in  1  multi-cycle mul/div occupying E
- br_redirect  in  1  taken branch/jump resolved in E; held while E is stalled
- trap_req  in  1  exception/interrupt taken at M
- trap_ret  in  1  mret retiring at M
- stall  out  1 x [N_STAGES-1:0] (unpacked)  per-stage hold
- flush  out  1 x [N_STAGES-1:0] (unpacked)  per-stage clear
- pc_load  out  1  fetch PC loads pc_sel source this cycle
- pc_sel  out  pc_sel_t  PC_SEQ / PC_BR / PC_TRAP / PC_EPC
- state  out  pctrl_state_t  current FSM state (debug)

Behaviour:
- Reset (grst at posedge): state=RUN, trap counter=0. While grst is asserted, outputs are forced to stall=0, flush=all 1, pc_load=0, pc_sel=PC_SEQ.
- Stall vector (combinational, cumulative toward F):
  - dmem_wait stalls F..M.
  - mdu_busy stalls F..E.
  - lu_hazard stalls F..D.
  - imem_wait stalls F.
  - stall[W] is always 0.
  - Bubbles downstream of the stall boundary come from pbuffer semantics; no flush is issued for them.
- Priority, high to low: trap_req/trap_ret > dmem_wait > mdu_busy > br_redirect > lu_hazard > imem_wait.
- Redirect acceptance: br_redirect is accepted only when stall[E]=0. On acceptance:
  - flush[F]=flush[D]=1, pc_load=1, pc_sel=PC_BR.
  - lu_hazard is ignored that cycle (D is wrong-path).
  - If imem_wait=1 at acceptance, next state is KILL; otherwise RUN.
- Trap: trap_req (or trap_ret) gives, same cycle:
  - flush[F..M]=1, stall all 0, pc_load=1, pc_sel=PC_TRAP (PC_EPC for trap_ret).
  - Overrides dmem_wait and mdu_busy.
  - Next state is TRAP_WAIT with counter=TRAP_CYCLES-1, and an in-flight-fetch flag set if imem_wait=1.
  - trap_req and trap_ret together: trap_req wins.
- FSM:
  - RUN: as above.
  - KILL: stall[F]=1 while imem_wait=1. When imem_wait drops, flush[F]=1 for that cycle (stale fetch discarded), then go to RUN. A trap in KILL takes the trap path.
  - TRAP_WAIT: stall[F]=1. D..M run normally (they hold bubbles). Counter decrements each cycle. When counter=0 and the in-flight flag is clear, go to RUN. If the flag is set, flush[F] fires on the cycle imem_wait drops and the flag clears. A nested trap_req restarts TRAP_WAIT.
  - br_redirect is ignored in TRAP_WAIT (E holds bubbles after a flush).
- Simultaneous events: a flush on a stage overrides a stall on the same stage. pc_load is at most one pulse per cycle.
- Mid-operation reset: grst in any state returns to RUN next cycle; counters and flags clear.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cyc[CNT_W] (counts cycles with stall[F]=1) and flush_evt[CNT_W] (counts cycles with flush[D]=1 and grst=0). Both cleared by grst and saturate at all-ones.
- Undefined: these ports and their counters do not exist.

Decomposition:
- defs.svh (shared package) gets:
  - pc_sel_t, pctrl_state_t {RUN, KILL, TRAP_WAIT}.
  - Stage indices via the existing stage_t (F=0..W=4) and N_STAGES.
- One sub-module, pipe_stall_vec: pure combinational priority/cumulative stall-flush encoder. The FSM and counters stay in pipe_ctrl.

Test Plan:
- Reset: hold grst 3 cycles in TRAP_WAIT -> flush all 1, stall all 0 while asserted; state=RUN, pc_load=0 after release.
- Load-use: lu_hazard=1 for 1 cycle -> stall={F:1,D:1,E:0,M:0,W:0}, flush=0; next cycle all 0.
- dmem_wait=1 for 3 cycles with br_redirect=1 -> stall F..M for 3 cycles, no pc_load. Cycle 4: pc_load=1, pc_sel=PC_BR, flush[F]=flush[D]=1.
- Redirect with imem_wait=1 held 2 more cycles -> state=KILL, stall[F]=1 for 2 cycles, then flush[F]=1 for 1 cycle, then RUN.
- trap_req with mdu_busy=1, TRAP_CYCLES=2 -> same cycle: flush F..M=1, pc_sel=PC_TRAP, pc_load=1; then stall[F]=1 for exactly 2 cycles, then RUN.
- PIPE_CTRL_PERF_EN: 5 stall cycles + 2 redirects -> stall_cyc=5, flush_evt=2; a trap_req adds 1 to flush_evt.
